// File: rtl/fifo_pkt_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkt_pkg
// Shared types and constants for the FIFO packetizer.
//   pkt_byte_t       : one stream / FIFO byte
//   pkt_state_t      : packetizer FSM states
//   SOF_BYTE_DEFAULT : default start-of-frame marker
//   chk_fold()       : folds one byte into the running XOR checksum
// -----------------------------------------------------------------------------
package fifo_pkt_pkg;

   typedef logic [7:0] pkt_byte_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SOF     = 3'd1,
      ST_FETCH   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_LEN     = 3'd5,
      ST_CHK     = 3'd6
   } pkt_state_t;

   localparam pkt_byte_t SOF_BYTE_DEFAULT = 8'hA5;

   // Running frame checksum is a plain XOR of every byte after SOF.
   function automatic pkt_byte_t chk_fold(input pkt_byte_t chk, input pkt_byte_t b);
      return chk ^ b;
   endfunction

endpackage

// File: rtl/fifo_packetizer.sv
// -----------------------------------------------------------------------------
// fifo_packetizer
// Pops bytes from an 8-bit FIFO and emits frames on a valid/ready byte stream:
//   SOF_BYTE, 1..MAX_PAYLOAD payload bytes, LEN (payload count), CHK (XOR of
//   payload bytes and LEN). out_last marks the CHK byte.
//
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   rd_empty   : FIFO empty flag
//   rd_data    : FIFO read data, valid the cycle after the edge sampling rd_en=1
//   rd_en      : FIFO pop request (registered)
//   out_data   : frame byte (registered)
//   out_valid  : out_data valid (registered)
//   out_last   : marks CHK byte (registered)
//   out_ready  : downstream accept
//   busy       : high whenever the FSM is not idle (registered)
//
// Build option:
//   FIFO_PKT_TIMEOUT_EN : when defined, an open frame that sees the FIFO empty
//                         for IDLE_TIMEOUT cycles is closed early (short frame).
// -----------------------------------------------------------------------------
module fifo_packetizer
   import fifo_pkt_pkg::*;
#(
   parameter int        MAX_PAYLOAD  = 8,
   parameter pkt_byte_t SOF_BYTE     = SOF_BYTE_DEFAULT,
   parameter int        IDLE_TIMEOUT = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rd_empty,
   input  logic [7:0] rd_data,
   output logic       rd_en,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   output logic       busy
);

   localparam pkt_byte_t MAX_B = pkt_byte_t'(MAX_PAYLOAD);

   // Elaboration-time guard on the parameter ranges.
   if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 255 || IDLE_TIMEOUT < 1) begin : g_param_check
      $error("fifo_packetizer: MAX_PAYLOAD must be 1..255 and IDLE_TIMEOUT >= 1");
   end

   pkt_state_t state_r;
   pkt_byte_t  count_r;
   pkt_byte_t  chk_r;
   pkt_byte_t  count_inc_s;
   logic       accept_s;

   assign count_inc_s = count_r + 8'd1;
   assign accept_s    = out_valid & out_ready;

`ifdef FIFO_PKT_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_r;
`endif

   // Packetizer FSM with its datapath registers and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         count_r   <= 8'd0;
         chk_r     <= 8'd0;
         rd_en     <= 1'b0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
`ifdef FIFO_PKT_TIMEOUT_EN
         tmo_r     <= {TMO_W{1'b0}};
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!rd_empty) begin
                  state_r   <= ST_SOF;
                  out_data  <= SOF_BYTE;
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  busy      <= 1'b0;
               end
            end
            ST_SOF: begin
               if (accept_s) begin
                  state_r   <= ST_FETCH;
                  out_valid <= 1'b0;
               end else begin
                  state_r   <= ST_SOF;
               end
            end
            ST_FETCH: begin
               if (!rd_empty) begin
                  rd_en   <= 1'b1;
                  state_r <= ST_WAIT;
`ifdef FIFO_PKT_TIMEOUT_EN
                  tmo_r   <= {TMO_W{1'b0}};
`endif
               end else begin
`ifdef FIFO_PKT_TIMEOUT_EN
                  // Only an open frame (at least one payload byte) may time out.
                  if (count_r != 8'd0) begin
                     if (tmo_r == TMO_LAST) begin
                        tmo_r     <= {TMO_W{1'b0}};
                        state_r   <= ST_LEN;
                        out_data  <= count_r;
                        out_valid <= 1'b1;
                     end else begin
                        tmo_r     <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     tmo_r <= {TMO_W{1'b0}};
                  end
`else
                  state_r <= ST_FETCH;
`endif
               end
            end
            ST_WAIT: begin
               // rd_en is still high during the first WAIT cycle, so the FIFO
               // pops on that edge; its data is captured one cycle later.
               if (rd_en) begin
                  rd_en <= 1'b0;
               end else begin
                  out_data  <= rd_data;
                  out_valid <= 1'b1;
                  state_r   <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (accept_s) begin
                  count_r <= count_inc_s;
                  chk_r   <= chk_fold(chk_r, out_data);
                  if (count_inc_s == MAX_B) begin
                     state_r  <= ST_LEN;
                     out_data <= count_inc_s;
                  end else begin
                     state_r   <= ST_FETCH;
                     out_valid <= 1'b0;
                  end
               end else begin
                  state_r <= ST_PAYLOAD;
               end
            end
            ST_LEN: begin
               if (accept_s) begin
                  chk_r    <= chk_fold(chk_r, out_data);
                  out_data <= chk_fold(chk_r, out_data);
                  out_last <= 1'b1;
                  state_r  <= ST_CHK;
               end else begin
                  state_r  <= ST_LEN;
               end
            end
            ST_CHK: begin
               if (accept_s) begin
                  state_r   <= ST_IDLE;
                  count_r   <= 8'd0;
                  chk_r     <= 8'd0;
                  out_data  <= 8'd0;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  state_r   <= ST_CHK;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               count_r   <= 8'd0;
               chk_r     <= 8'd0;
               rd_en     <= 1'b0;
               out_data  <= 8'd0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_packetizer.sv
// -----------------------------------------------------------------------------
// tb_fifo_packetizer
// Self-checking bench for fifo_packetizer: a behavioural FIFO feeds the DUT,
// a frame-level reference model builds the expected byte stream (SOF, payload,
// LEN, XOR checksum), and a per-cycle monitor compares accepted bytes, stall
// stability and pop spacing.
// -----------------------------------------------------------------------------
module tb_fifo_packetizer;
   import fifo_pkt_pkg::*;

   localparam int MAXP = 8;
   localparam int TMO  = 32;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rd_empty;
   logic [7:0] rd_data;
   logic       rd_en;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       busy;

   always #5 clk = ~clk;

   fifo_packetizer #(.MAX_PAYLOAD(MAXP), .SOF_BYTE(8'hA5), .IDLE_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .rd_empty(rd_empty), .rd_data(rd_data),
      .rd_en(rd_en), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_ready(out_ready), .busy(busy)
   );

   // ---------------- behavioural FIFO (registered empty flag) ----------------
   logic [7:0] fmem [256];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int underflow_n = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr   <= wr_ptr;
         rd_empty <= 1'b1;
         rd_data  <= 8'h00;
      end else if (rd_en) begin
         if (rd_ptr < wr_ptr) begin
            rd_data  <= fmem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
            rd_empty <= (rd_ptr + 1 >= wr_ptr);
         end else begin
            underflow_n <= underflow_n + 1;
            rd_empty    <= 1'b1;
         end
      end else begin
         rd_empty <= (rd_ptr >= wr_ptr);
      end
   end

   task automatic push_byte(input logic [7:0] b);
      fmem[wr_ptr] = b;
      wr_ptr++;
   endtask

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       is_len;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] pay_q[$];

   // Expected frame for the payload currently in pay_q.
   task automatic frame_exp();
      logic [7:0] x;
      logic [7:0] len;
      x   = 8'h00;
      len = 8'(pay_q.size());
      exp_q.push_back('{d: 8'hA5, l: 1'b0, is_len: 1'b0});
      foreach (pay_q[i]) begin
         exp_q.push_back('{d: pay_q[i], l: 1'b0, is_len: 1'b0});
         x = x ^ pay_q[i];
      end
      exp_q.push_back('{d: len, l: 1'b0, is_len: 1'b1});
      exp_q.push_back('{d: x ^ len, l: 1'b1, is_len: 1'b0});
   endtask

   // ---------------- monitor state ----------------
   int         cyc = 0;
   int         gap = 100;
   int         pops = 0;
   int         last_pop_cyc = 0;
   int         len_cyc = 0;
   int         acc_n = 0;
   int         stalls = 0;
   bit         stall_pend = 1'b0;
   logic [7:0] held_d;
   logic       held_l;
   bit         rand_ready = 1'b0;

   task automatic monitor();
      exp_t e;
      cyc++;
      if (reset_n) begin
         if (stall_pend) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_data", 32'(out_data), 32'(held_d));
            check_eq("stall_last", 32'(out_last), 32'(held_l));
         end
         if (rd_en) begin
            check_eq("rd_en_spacing", 32'(gap >= 3), 32'd1);
            gap = 0;
            pops++;
            last_pop_cyc = cyc;
         end else begin
            gap++;
         end
         if (out_valid) begin
            check_eq("rd_en_while_valid", 32'(rd_en), 32'd0);
            check_eq("busy_while_valid", 32'(busy), 32'd1);
         end
         if (out_valid && out_ready) begin
            check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("out_data", 32'(out_data), 32'(e.d));
               check_eq("out_last", 32'(out_last), 32'(e.l));
               if (e.is_len) len_cyc = cyc;
            end
            acc_n++;
            stall_pend = 1'b0;
         end else if (out_valid) begin
            stall_pend = 1'b1;
            held_d     = out_data;
            held_l     = out_last;
            stalls++;
         end else begin
            stall_pend = 1'b0;
         end
      end
   endtask

   // One clock: sample at negedge, then drive inputs just after the posedge.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Run until at most 'leave' expected bytes remain, bounded by 'budget'.
   task automatic drain(input int leave, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > leave && n < budget) begin
         step();
         n++;
      end
      check_eq("drain", 32'(exp_q.size()), 32'(leave));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_data"}, 32'(out_data), 32'd0);
      check_eq({tag, "_last"}, 32'(out_last), 32'd0);
   endtask

   initial begin
      int n;
      out_ready = 1'b1;
      reset_n   = 1'b1;
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Empty FIFO: nothing happens.
      repeat (100) begin
         step();
         check_eq("idle_valid", 32'(out_valid), 32'd0);
         check_eq("idle_rd_en", 32'(rd_en), 32'd0);
         check_eq("idle_busy", 32'(busy), 32'd0);
      end

      // Full frame 01..08.
      pops = 0;
      pay_q.delete();
      for (int i = 1; i <= 8; i++) begin
         push_byte(8'(i));
         pay_q.push_back(8'(i));
      end
      frame_exp();
      drain(0, 300);
      check_eq("frame1_pops", 32'(pops), 32'd8);

      // 10 bytes 10..19 across two frames.
      pay_q.delete();
      for (int i = 0; i < 10; i++) push_byte(8'(8'h10 + i));
      for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'h10 + i));
      frame_exp();
`ifdef FIFO_PKT_TIMEOUT_EN
      pay_q.delete();
      pay_q.push_back(8'h18);
      pay_q.push_back(8'h19);
      frame_exp();
      drain(0, 600);

      // Short frame closed by the idle timeout.
      pay_q.delete();
      push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
      pay_q.push_back(8'hAA); pay_q.push_back(8'hBB); pay_q.push_back(8'hCC);
      frame_exp();
      drain(0, 300);
      check_eq("timeout_len_min", 32'((len_cyc - last_pop_cyc) >= TMO), 32'd1);
      check_eq("timeout_len_max", 32'((len_cyc - last_pop_cyc) <= TMO + 8), 32'd1);
`else
      pay_q.delete();
      for (int i = 0; i < 8; i++) pay_q.push_back(8'(8'h18 + i));
      frame_exp();
      drain(8, 600);
      repeat (60) step();
      check_eq("open_frame_busy", 32'(busy), 32'd1);
      check_eq("open_frame_hold", 32'(exp_q.size()), 32'd8);
      for (int i = 2; i < 8; i++) push_byte(8'(8'h18 + i));
      drain(0, 300);
`endif

      // Random payloads with random backpressure.
      stalls = 0;
      rand_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         pay_q.delete();
         for (int i = 0; i < 8; i++) begin
            pay_q.push_back(8'($urandom_range(0, 255)));
            push_byte(pay_q[i]);
         end
         frame_exp();
      end
      drain(0, 2000);
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      check_eq("stalls_seen", 32'(stalls > 0), 32'd1);

      // Reset during a PAYLOAD stall, then a fresh frame.
      repeat (5) step();
      pay_q.delete();
      for (int i = 0; i < 8; i++) begin
         push_byte(8'(8'h30 + i));
         pay_q.push_back(8'(8'h30 + i));
      end
      frame_exp();
      n = acc_n;
      for (int k = 0; k < 200 && acc_n < n + 3; k++) step();
      check_eq("reach_payload", 32'(acc_n - n), 32'd3);
      out_ready = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) step();
      check_eq("stalled_byte", 32'(out_data), 32'h32);
      check_eq("stalled_valid", 32'(out_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      exp_q.delete();
      stall_pend = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      pay_q.delete();
      for (int i = 0; i < 8; i++) begin
         push_byte(8'(8'h40 + i));
         pay_q.push_back(8'(8'h40 + i));
      end
      frame_exp();
      drain(0, 300);

      repeat (5) step();
      check_eq("final_idle", 32'(busy), 32'd0);
      check_eq("fifo_underflow", 32'(underflow_n), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
